conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Streaming 3x3 window generator that sits directly upstream of image_filter.
//  Accepts one raster-order pixel per handshake, buffers two image rows in line buffers and
//  emits every full 3x3 neighbourhood (valid convolution only): (IMG_W-2)*(IMG_H-2) windows per frame.
//  With the defaults this is 10x10 pixels in and 64 windows out, which image_filter reduces to A[1:64].
// PARAMETERS
//  IMG_W   10  pixels per row (>=3)
//  IMG_H   10  rows per frame (>=3)
//  PIX_W    8  bits per pixel
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  in_pix     in   PIX_W    input pixel, raster order (row-major, top-left first)
//  in_valid   in   1        in_pix is valid
//  in_ready   out  1        block can accept a pixel this cycle
//  win        out  9*PIX_W  3x3 window; [9*PIX_W-1 -: PIX_W] = w1 (top-left) ... [PIX_W-1:0] = w9 (bottom-right)
//  win_valid  out  1        win is valid
//  win_ready  in   1        downstream accepts win
//  win_last   out  1        win is the final window of the frame
//  win_idx    out  16       window index 0..(IMG_W-2)*(IMG_H-2)-1 (only when WIN_INDEX_EN is defined)
// BEHAVIOUR
//  - Reset (rst=0, async): col=0, row=0, win_valid=0, win_last=0, win=0, win_idx=0. in_ready=1 once reset is released.
//    Line-buffer contents are don't-care: windows never use rows 0-1 of a frame before they are rewritten.
//  - Accept: a pixel is accepted when in_valid && in_ready. in_ready = !win_valid || win_ready,
//    i.e. one output register with pass-through backpressure.
//  - Per accepted pixel at (row, col):
//    - the 3-column shift window advances and takes {lb1[col], lb0[col], in_pix} as its new right column;
//    - lb1[col] <= lb0[col] and lb0[col] <= in_pix. lb0 holds row-1 and lb1 holds row-2; each is IMG_W deep,
//      addressed by col;
//    - col increments. When col==IMG_W-1 it wraps to 0 and row increments.
//      When row==IMG_H-1 and col==IMG_W-1, both wrap to 0 (start of next frame).
//  - Emit: if row>=2 && col>=2 at accept, win_valid is set on the next edge, so latency is 1 cycle from accept.
//    Otherwise win_valid clears if win_ready was high, or holds if it was low.
//  - Window contents for the pixel at (r,c):
//    w1..w3 = P(r-2, c-2..c), w4..w6 = P(r-1, c-2..c), w7..w9 = P(r, c-2..c).
//    The shift window is not cleared at row wrap; columns 0-1 never emit, so stale columns are never output.
//  - win_last = 1 with the window for (IMG_H-1, IMG_W-1).
//  - While win_valid && !win_ready: win, win_last and win_idx hold stable, in_ready=0, and no pixel is consumed.
//  - Simultaneous handshakes: win_valid && win_ready && in_valid on the same cycle replaces the window in one cycle,
//    giving a sustained throughput of 1 pixel/cycle.
//  - Frames run back-to-back with no gap cycle. No arithmetic is done here; pixels pass through unmodified.
//  - Counters are clog2(IMG_W) and clog2(IMG_H) bits wide. win_idx is 16 bits and wraps to 0 after win_last is accepted.
// CONFIGURATION
//  WIN_INDEX_EN defined:
//    - win_idx port exists; it increments on each window accept and resets to 0 after win_last or on reset.
//  WIN_INDEX_EN undefined:
//    - the win_idx port and its counter are absent; all other behaviour is identical.
// TESTING
//  1. Ramp in_pix = 1..100, in_valid=1, win_ready=1
//     -> exactly 64 windows.
//     -> first window = {1,2,3,11,12,13,21,22,23}, 1 cycle after pixel 23 is accepted.
//     -> 64th window = {78,79,80,88,89,90,98,99,100} with win_last=1.
//  2. Same ramp, win_ready=0 for 5 cycles while the 10th window is valid
//     -> win stable, in_ready=0 for those 5 cycles.
//     -> window sequence identical to test 1; no pixel lost or duplicated.
//  3. Same ramp with in_valid=0 on every 3rd cycle
//     -> the same 64 windows in the same order; win_valid=0 during gaps once the window has been accepted.
//  4. Two back-to-back frames (ramp 1..100, then 101..200 mod 256)
//     -> 128 windows.
//     -> window 65 = {101,102,103,111,112,113,121,122,123}; win_last on windows 64 and 128 only.
//  5. Assert rst=0 mid-frame after 37 pixels
//     -> win_valid=0 and win_last=0 immediately, without waiting for clk.
//     -> after release, a fresh ramp 1..100 reproduces test 1 exactly.
//  6. WIN_INDEX_EN defined, ramp as in test 1
//     -> win_idx = 0..63 in order; 63 coincides with win_last; win_idx = 0 on the first window of the next frame.

Source files
------------

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Streaming 3x3 window generator. Takes one raster-order pixel per handshake,
//   keeps the two previous image rows in line buffers and emits every complete
//   3x3 neighbourhood (valid convolution only): (IMG_W-2)*(IMG_H-2) windows per
//   frame. Frames run back-to-back. Pixels pass through unmodified.
//
//   Optional feature macro: WIN_INDEX_EN -- adds the win_idx port and counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_pix     input pixel (raster order, top-left first)
//   in_valid   in_pix valid
//   in_ready   pixel can be accepted this cycle
//   win        3x3 window, w1 (top-left) in the MSBs ... w9 (bottom-right) in the LSBs
//   win_valid  win valid
//   win_ready  downstream accepts win
//   win_last   win is the final window of the frame
//   win_idx    window index within the frame (WIN_INDEX_EN only)
// -----------------------------------------------------------------------------
module conv_window_gen #(
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int PIX_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   in_pix,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [9*PIX_W-1:0] win,
   output logic               win_valid,
   input  logic               win_ready,
   output logic               win_last
`ifdef WIN_INDEX_EN
   ,
   output logic [15:0]        win_idx
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // lb0 holds row-1, lb1 holds row-2, both addressed by column
   logic [PIX_W-1:0] lb0 [IMG_W];
   logic [PIX_W-1:0] lb1 [IMG_W];

   // Two previous columns of the sliding window; [2]=top, [1]=mid, [0]=bottom.
   // The incoming column is the third, so no third register is needed.
   logic [2:0][PIX_W-1:0] sc1, sc2, ncol;

   logic                 accept, emit, col_end, row_end;
   logic [9*PIX_W-1:0]   win_nxt;

   assign in_ready = !win_valid || win_ready;
   assign accept   = in_valid && in_ready;
   assign col_end  = (col == CW'(IMG_W - 1));
   assign row_end  = (row == RW'(IMG_H - 1));
   assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

   assign ncol    = {lb1[col], lb0[col], in_pix};
   assign win_nxt = {sc1[2], sc2[2], ncol[2],
                     sc1[1], sc2[1], ncol[1],
                     sc1[0], sc2[0], ncol[0]};

   // Line buffers need no reset: rows 0-1 of a frame are rewritten before any
   // window can read them.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= in_pix;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col       <= '0;
         row       <= '0;
         sc1       <= '0;
         sc2       <= '0;
         win       <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         if (accept) begin
            // Window columns are not cleared on row wrap; columns 0-1 never
            // emit, so stale data never reaches the output.
            sc1 <= sc2;
            sc2 <= ncol;
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (emit) begin
            win       <= win_nxt;
            win_valid <= 1'b1;
            win_last  <= col_end && row_end;
         end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

`ifdef WIN_INDEX_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_idx <= '0;
      end else if (win_valid && win_ready) begin
         win_idx <= win_last ? 16'd0 : win_idx + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//   Drives pixel frames into conv_window_gen and checks every output window
//   against a frame-array model: each accepted pixel is stored at its raster
//   position and, when a full 3x3 neighbourhood exists, the expected window is
//   read straight out of that array and queued.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

   localparam int W  = 10;
   localparam int H  = 10;
   localparam int P  = 8;
   localparam int NW = (W - 2) * (H - 2);

   typedef logic [9*P-1:0] win_t;
   typedef struct {
      win_t w;
      bit   last;
      int   idx;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [P-1:0] in_pix = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   win_t         win;
   logic         win_valid;
   logic         win_ready = 1'b1;
   logic         win_last;
`ifdef WIN_INDEX_EN
   logic [15:0]  win_idx;
`endif

   always #5 clk = ~clk;

   conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid),
      .in_ready(in_ready), .win(win), .win_valid(win_valid),
      .win_ready(win_ready), .win_last(win_last)
`ifdef WIN_INDEX_EN
      , .win_idx(win_idx)
`endif
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input bit ok, input win_t act, input win_t exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic win_t mk(input int a, b, c, d, e, f, g, h, i);
      return {P'(a), P'(b), P'(c), P'(d), P'(e), P'(f), P'(g), P'(h), P'(i)};
   endfunction

   // ---------------- model state ----------------
   exp_t         expq[$];
   int           pix_k = 0;
   logic [P-1:0] frame [H][W];
   int           win_cnt = 0, last_cnt = 0, stall_cycles = 0;
   win_t         win_log [256];
   bit           last_log [256];
   int           idx_log [256];
   bit           pend = 0;
   win_t         pend_win;
   bit           prev_stall = 0;
   win_t         prev_win;
   bit           prev_last;

   // stimulus controls
   int ready_mode = 0;   // 0: always ready, 1: one 5-cycle stall on window 10, 2: random
   bit stall_done = 0;
   bit gap_mode = 0;
   bit rand_valid = 0;
   int cyc = 0;

   function automatic void model_accept(input logic [P-1:0] pix);
      int pos, r, c;
      exp_t e;
      pos = pix_k % (W * H);
      r = pos / W;
      c = pos % W;
      frame[r][c] = pix;
      if (r >= 2 && c >= 2) begin
         for (int i = 0; i < 9; i++)
            e.w[(8 - i) * P +: P] = frame[r - 2 + i / 3][c - 2 + i % 3];
         e.last = (r == H - 1) && (c == W - 1);
         e.idx  = (r - 2) * (W - 2) + (c - 2);
         expq.push_back(e);
         pend     = 1;
         pend_win = e.w;
      end
      pix_k++;
   endfunction

   // ---------------- compare process (away from the active edge) ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (pend) begin
            chk("latency", win_valid === 1'b1 && win === pend_win, win, pend_win);
            pend = 0;
         end
         if (prev_stall)
            chk("stall_hold", win_valid === 1'b1 && win === prev_win && win_last === prev_last,
                win, prev_win);
         if (win_valid && !win_ready) begin
            stall_cycles++;
            chk("stall_in_ready", in_ready === 1'b0, win_t'(in_ready), win_t'(0));
         end
         prev_stall = win_valid && !win_ready;
         prev_win   = win;
         prev_last  = win_last;
         if (win_valid && win_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_window", 1'b0, win, win_t'(0));
            end else begin
               e = expq.pop_front();
               chk("win", win === e.w, win, e.w);
               chk("win_last", win_last === e.last, win_t'(win_last), win_t'(e.last));
`ifdef WIN_INDEX_EN
               chk("win_idx", win_idx === 16'(e.idx), win_t'(win_idx), win_t'(e.idx));
`endif
            end
            if (win_cnt < 256) begin
               win_log[win_cnt]  = win;
               last_log[win_cnt] = win_last;
`ifdef WIN_INDEX_EN
               idx_log[win_cnt]  = int'(win_idx);
`else
               idx_log[win_cnt]  = -1;
`endif
            end
            win_cnt++;
            if (win_last) last_cnt++;
         end
         if (in_valid && in_ready) model_accept(in_pix);
      end
   end

   // ---------------- downstream ready ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               if (!stall_done && win_valid && win_cnt == 9) begin
                  win_ready  = 1'b0;
                  stall_done = 1;
                  repeat (4) @(posedge clk);
               end else begin
                  win_ready = 1'b1;
               end
            end
            2: win_ready = ($urandom_range(0, 9) < 7);
            default: win_ready = 1'b1;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [P-1:0] pix);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      in_pix = pix;
      while (!acc && t < 200) begin
         if (gap_mode)        in_valid = (cyc % 3 != 2);
         else if (rand_valid) in_valid = ($urandom_range(0, 3) != 0);
         else                 in_valid = 1'b1;
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         t++;
      end
      if (!acc) chk("send_timeout", 1'b0, win_t'(0), win_t'(1));
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int base);
      for (int i = 0; i < W * H; i++) send(P'((base + i) % 256));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (win_valid && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain", expq.size() == 0 && win_valid === 1'b0, win_t'(expq.size()), win_t'(0));
   endtask

   task automatic clear_model();
      expq.delete();
      pix_k = 0;
      pend = 0;
      prev_stall = 0;
      win_cnt = 0;
      last_cnt = 0;
      stall_cycles = 0;
      stall_done = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
   endtask

   task automatic check_ramp_frame(input string tag);
      chk({tag, "_count"}, win_cnt == NW, win_t'(win_cnt), win_t'(NW));
      chk({tag, "_first"}, win_log[0] === mk(1, 2, 3, 11, 12, 13, 21, 22, 23),
          win_log[0], mk(1, 2, 3, 11, 12, 13, 21, 22, 23));
      chk({tag, "_last_win"}, win_log[NW-1] === mk(78, 79, 80, 88, 89, 90, 98, 99, 100),
          win_log[NW-1], mk(78, 79, 80, 88, 89, 90, 98, 99, 100));
      chk({tag, "_last_flag"}, last_log[NW-1] == 1 && last_cnt == 1,
          win_t'(last_cnt), win_t'(1));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // reset state
      #12;
      chk("rst_win_valid", win_valid === 1'b0, win_t'(win_valid), win_t'(0));
      chk("rst_win_last", win_last === 1'b0, win_t'(win_last), win_t'(0));
      chk("rst_win", win === '0, win, win_t'(0));
`ifdef WIN_INDEX_EN
      chk("rst_win_idx", win_idx === 16'd0, win_t'(win_idx), win_t'(0));
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_in_ready", in_ready === 1'b1, win_t'(in_ready), win_t'(1));

      // 1: plain ramp
      run_frame(1);
      drain();
      check_ramp_frame("t1");

      // 2: 5-cycle stall on window 10
      do_reset();
      ready_mode = 1;
      run_frame(1);
      drain();
      ready_mode = 0;
      check_ramp_frame("t2");
      chk("t2_stall_cycles", stall_cycles == 5, win_t'(stall_cycles), win_t'(5));

      // 3: in_valid low every 3rd cycle
      do_reset();
      gap_mode = 1;
      run_frame(1);
      drain();
      gap_mode = 0;
      check_ramp_frame("t3");

      // 4: two back-to-back frames
      do_reset();
      run_frame(1);
      run_frame(101);
      drain();
      chk("t4_count", win_cnt == 2 * NW, win_t'(win_cnt), win_t'(2 * NW));
      chk("t4_win65", win_log[NW] === mk(101, 102, 103, 111, 112, 113, 121, 122, 123),
          win_log[NW], mk(101, 102, 103, 111, 112, 113, 121, 122, 123));
      chk("t4_last_flags", last_log[NW-1] == 1 && last_log[2*NW-1] == 1 && last_cnt == 2,
          win_t'(last_cnt), win_t'(2));
`ifdef WIN_INDEX_EN
      // 6: index sequence across the frame boundary
      chk("t6_idx_63", idx_log[NW-1] == NW - 1, win_t'(idx_log[NW-1]), win_t'(NW - 1));
      chk("t6_idx_wrap", idx_log[NW] == 0, win_t'(idx_log[NW]), win_t'(0));
`endif

      // 5: asynchronous reset mid-frame
      do_reset();
      for (int i = 1; i <= 37; i++) send(P'(i));
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_valid", win_valid === 1'b0, win_t'(win_valid), win_t'(0));
      chk("t5_async_last", win_last === 1'b0, win_t'(win_last), win_t'(0));
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_frame(1);
      drain();
      check_ramp_frame("t5");

      // randomized: random pixels, random valid and ready, two frames
      do_reset();
      rand_valid = 1;
      ready_mode = 2;
      for (int i = 0; i < 2 * W * H; i++) send(P'($urandom_range(0, 255)));
      ready_mode = 0;
      rand_valid = 0;
      drain();
      chk("rand_count", win_cnt == 2 * NW, win_t'(win_cnt), win_t'(2 * NW));
      chk("rand_last_cnt", last_cnt == 2, win_t'(last_cnt), win_t'(2));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
